// File: rtl/st7789_spi_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : st7789_spi_rx
//  Description : Receive-side model of the ST7789 panel write interface.
//                Deserializes the 9-bit (DC + 8-bit) SPI mode-2 MSB-first
//                link, decodes CASET / RASET / RAMWR / SWRESET and emits
//                pixel writes addressed {y[7:0], x[7:0]}.
//  Ports       : clk_i, rst_i (async, active-high)
//                sda_i, scl_i, dc_i, res_i   raw panel-side inputs
//                byte_valid_o/byte_o/byte_dc_o  received byte stream
//                px_we_o/px_addr_o/px_data_o    pixel write port
//                frame_done_o                   last pixel of the window
//  Revision    : 1.0  initial release
// ============================================================================
module st7789_spi_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int DEF_XE      = 239,
    parameter int DEF_YE      = 239
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sda_i,
    input  logic        scl_i,
    input  logic        dc_i,
    input  logic        res_i,
    output logic        byte_valid_o,
    output logic [7:0]  byte_o,
    output logic        byte_dc_o,
    output logic        px_we_o,
    output logic [15:0] px_addr_o,
    output logic [15:0] px_data_o,
    output logic        frame_done_o
);

    localparam logic [7:0] C_CMD_SWRESET = 8'h01;
    localparam logic [7:0] C_CMD_CASET   = 8'h2A;
    localparam logic [7:0] C_CMD_RASET   = 8'h2B;
    localparam logic [7:0] C_CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] C_DEF_XE      = 8'(DEF_XE);
    localparam logic [7:0] C_DEF_YE      = 8'(DEF_YE);
    localparam logic [2:0] C_IDX_SAT     = 3'd4;
    // Synchronizer lane order {res, dc, sda, scl}; idle levels res=1, scl=1.
    localparam logic [3:0] C_SYNC_RST    = 4'b1001;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] sync_d [SYNC_STAGES];

    always_comb begin
        sync_d[0] = {res_i, dc_i, sda_i, scl_i};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= C_SYNC_RST;
            end
        end else begin
            sync_q <= sync_d;
        end
    end

    logic w_scl;
    logic w_sda;
    logic w_dc;
    logic w_res;
    logic w_scl_fall;

    assign {w_res, w_dc, w_sda, w_scl} = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        scl_prev_q,   scl_prev_d;
    logic [2:0]  bit_cnt_q,    bit_cnt_d;
    logic [6:0]  shift_q,      shift_d;
    logic [7:0]  byte_q,       byte_d;
    logic        byte_dc_q,    byte_dc_d;
    logic        byte_done_q,  byte_done_d;
    logic        byte_valid_q, byte_valid_d;
    logic [7:0]  cur_cmd_q,    cur_cmd_d;
    logic [2:0]  param_idx_q,  param_idx_d;
    logic        hi_pend_q,    hi_pend_d;
    logic [7:0]  hi_q,         hi_d;
    logic [7:0]  xs_q,         xs_d;
    logic [7:0]  ys_q,         ys_d;
    logic [7:0]  xe_q,         xe_d;
    logic [7:0]  ye_q,         ye_d;
    logic [7:0]  x_q,          x_d;
    logic [7:0]  y_q,          y_d;
    logic        px_we_q,      px_we_d;
    logic [15:0] px_addr_q,    px_addr_d;
    logic [15:0] px_data_q,    px_data_d;
    logic        frame_done_q, frame_done_d;

    assign w_scl_fall = scl_prev_q & ~w_scl;

    always_comb begin
        scl_prev_d   = w_scl;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_d       = byte_q;
        byte_dc_d    = byte_dc_q;
        byte_done_d  = 1'b0;
        byte_valid_d = 1'b0;
        cur_cmd_d    = cur_cmd_q;
        param_idx_d  = param_idx_q;
        hi_pend_d    = hi_pend_q;
        hi_d         = hi_q;
        xs_d         = xs_q;
        ys_d         = ys_q;
        xe_d         = xe_q;
        ye_d         = ye_q;
        x_d          = x_q;
        y_d          = y_q;
        px_we_d      = 1'b0;
        px_addr_d    = px_addr_q;
        px_data_d    = px_data_q;
        frame_done_d = 1'b0;

        // Bit capture: only the falling edge of SCL matters.
        if (w_scl_fall) begin
            shift_d   = {shift_q[5:0], w_sda};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_d      = {shift_q, w_sda};
                byte_dc_d   = w_dc;
                byte_done_d = 1'b1;
            end
        end

        // Byte decode runs one cycle after capture so that byte_valid_o
        // and px_we_o for the same byte land in the same cycle.
        if (byte_done_q) begin
            byte_valid_d = 1'b1;
            if (!byte_dc_q) begin
                cur_cmd_d   = byte_q;
                param_idx_d = 3'd0;
                hi_pend_d   = 1'b0;  // a half pixel in flight is dropped
                case (byte_q)
                    C_CMD_SWRESET: begin
                        xs_d = 8'd0;
                        ys_d = 8'd0;
                        xe_d = C_DEF_XE;
                        ye_d = C_DEF_YE;
                    end
                    C_CMD_RAMWR: begin
                        x_d = xs_q;
                        y_d = ys_q;
                    end
                    default: ;
                endcase
            end else begin
                case (cur_cmd_q)
                    C_CMD_CASET, C_CMD_RASET: begin
                        if (param_idx_q != C_IDX_SAT) begin
                            param_idx_d = param_idx_q + 3'd1;
                            // Index 0/2 carry the unused high bytes.
                            if (param_idx_q == 3'd1) begin
                                if (cur_cmd_q == C_CMD_CASET) xs_d = byte_q;
                                else                          ys_d = byte_q;
                            end else if (param_idx_q == 3'd3) begin
                                if (cur_cmd_q == C_CMD_CASET) xe_d = byte_q;
                                else                          ye_d = byte_q;
                            end
                        end
                    end
                    C_CMD_RAMWR: begin
                        if (!hi_pend_q) begin
                            hi_d      = byte_q;
                            hi_pend_d = 1'b1;
                        end else begin
                            hi_pend_d = 1'b0;
                            px_we_d   = 1'b1;
                            px_addr_d = {y_q, x_q};
                            px_data_d = {hi_q, byte_q};
                            // Equality-only compare: a window with start > end
                            // wraps through 255 until it meets the end value.
                            if (x_q != xe_q) begin
                                x_d = x_q + 8'd1;
                            end else if (y_q != ye_q) begin
                                x_d = xs_q;
                                y_d = y_q + 8'd1;
                            end else begin
                                x_d          = xs_q;
                                y_d          = ys_q;
                                frame_done_d = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        // Panel hardware reset: same state as rst_i, held while low.
        if (!w_res) begin
            scl_prev_d   = 1'b1;
            bit_cnt_d    = 3'd0;
            shift_d      = 7'd0;
            byte_d       = 8'd0;
            byte_dc_d    = 1'b0;
            byte_done_d  = 1'b0;
            byte_valid_d = 1'b0;
            cur_cmd_d    = 8'd0;
            param_idx_d  = 3'd0;
            hi_pend_d    = 1'b0;
            hi_d         = 8'd0;
            xs_d         = 8'd0;
            ys_d         = 8'd0;
            xe_d         = C_DEF_XE;
            ye_d         = C_DEF_YE;
            x_d          = 8'd0;
            y_d          = 8'd0;
            px_we_d      = 1'b0;
            px_addr_d    = 16'd0;
            px_data_d    = 16'd0;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_prev_q   <= 1'b1;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 7'd0;
            byte_q       <= 8'd0;
            byte_dc_q    <= 1'b0;
            byte_done_q  <= 1'b0;
            byte_valid_q <= 1'b0;
            cur_cmd_q    <= 8'd0;
            param_idx_q  <= 3'd0;
            hi_pend_q    <= 1'b0;
            hi_q         <= 8'd0;
            xs_q         <= 8'd0;
            ys_q         <= 8'd0;
            xe_q         <= C_DEF_XE;
            ye_q         <= C_DEF_YE;
            x_q          <= 8'd0;
            y_q          <= 8'd0;
            px_we_q      <= 1'b0;
            px_addr_q    <= 16'd0;
            px_data_q    <= 16'd0;
            frame_done_q <= 1'b0;
        end else begin
            scl_prev_q   <= scl_prev_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_q       <= byte_d;
            byte_dc_q    <= byte_dc_d;
            byte_done_q  <= byte_done_d;
            byte_valid_q <= byte_valid_d;
            cur_cmd_q    <= cur_cmd_d;
            param_idx_q  <= param_idx_d;
            hi_pend_q    <= hi_pend_d;
            hi_q         <= hi_d;
            xs_q         <= xs_d;
            ys_q         <= ys_d;
            xe_q         <= xe_d;
            ye_q         <= ye_d;
            x_q          <= x_d;
            y_q          <= y_d;
            px_we_q      <= px_we_d;
            px_addr_q    <= px_addr_d;
            px_data_q    <= px_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_o       = byte_q;
    assign byte_dc_o    = byte_dc_q;
    assign px_we_o      = px_we_q;
    assign px_addr_o    = px_addr_q;
    assign px_data_o    = px_data_q;
    assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_st7789_spi_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_st7789_spi_rx
//  Description : Directed self-checking bench for st7789_spi_rx. Drives the
//                SPI mode-2 link bit by bit and compares the logged byte and
//                pixel streams against hand-computed expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_st7789_spi_rx;

    localparam int SYNC_STAGES = 2;

    logic        clk   = 1'b0;
    logic        rst_i = 1'b1;
    logic        sda_i = 1'b0;
    logic        scl_i = 1'b1;
    logic        dc_i  = 1'b0;
    logic        res_i = 1'b1;
    logic        byte_valid_o;
    logic [7:0]  byte_o;
    logic        byte_dc_o;
    logic        px_we_o;
    logic [15:0] px_addr_o;
    logic [15:0] px_data_o;
    logic        frame_done_o;

    st7789_spi_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEF_XE      (239),
        .DEF_YE      (239)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .sda_i        (sda_i),
        .scl_i        (scl_i),
        .dc_i         (dc_i),
        .res_i        (res_i),
        .byte_valid_o (byte_valid_o),
        .byte_o       (byte_o),
        .byte_dc_o    (byte_dc_o),
        .px_we_o      (px_we_o),
        .px_addr_o    (px_addr_o),
        .px_data_o    (px_data_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int last_fall = 0;
    int stray_fd = 0;

    logic [7:0]  vb_q   [$];
    logic        vdc_q  [$];
    int          vcyc_q [$];
    logic [15:0] pa_q   [$];
    logic [15:0] pd_q   [$];
    logic        pf_q   [$];

    always @(negedge clk) begin
        if (byte_valid_o) begin
            vb_q.push_back(byte_o);
            vdc_q.push_back(byte_dc_o);
            vcyc_q.push_back(cyc);
        end
        if (px_we_o) begin
            pa_q.push_back(px_addr_o);
            pd_q.push_back(px_data_o);
            pf_q.push_back(frame_done_o);
        end else if (frame_done_o) begin
            stray_fd = stray_fd + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        vb_q.delete();
        vdc_q.delete();
        vcyc_q.delete();
        pa_q.delete();
        pd_q.delete();
        pf_q.delete();
    endtask

    // Sends the top n bits of b, MSB first; SDA/DC change while SCL is high.
    task automatic send_bits(input logic d, input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            @(posedge clk); #1;
            sda_i = b[i];
            dc_i  = d;
            repeat (2) @(posedge clk);
            #1;
            scl_i     = 1'b0;
            last_fall = cyc;
            repeat (3) @(posedge clk);
            #1;
            scl_i = 1'b1;
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic cmd(input logic [7:0] b);
        send_bits(1'b0, b, 8);
    endtask

    task automatic dat(input logic [7:0] b);
        send_bits(1'b1, b, 8);
    endtask

    task automatic pixel(input logic [15:0] p);
        dat(p[15:8]);
        dat(p[7:0]);
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
    endtask

    function automatic logic [43:0] all_outs();
        return {byte_valid_o, byte_o, byte_dc_o, px_we_o,
                px_addr_o, px_data_o, frame_done_o};
    endfunction

    logic [7:0]  exp1_b  [13] = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'hEF,
                                  8'h2B, 8'h00, 8'h00, 8'h00, 8'hEF,
                                  8'h2C, 8'hF8, 8'h00};
    logic        exp1_dc [13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                  1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                  1'b0, 1'b1, 1'b1};
    logic [15:0] exp2_a  [5]  = '{16'h050A, 16'h050B, 16'h060A, 16'h060B, 16'h050A};
    logic        exp2_f  [5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] exp6_a  [3]  = '{16'hEFEE, 16'hEFEF, 16'hEFEE};
    logic        exp6_f  [3]  = '{1'b0, 1'b1, 1'b0};

    initial begin
        int f0;
        int nf;
        logic [15:0] ea;

        // ---------------- Test 1: reset state and first pixel ----------
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'(all_outs()), 64'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        repeat (3) @(posedge clk);
        clear_logs();
        cmd(8'h2A);
        f0 = last_fall;
        dat(8'h00); dat(8'h00); dat(8'h00); dat(8'hEF);
        cmd(8'h2B);
        dat(8'h00); dat(8'h00); dat(8'h00); dat(8'hEF);
        cmd(8'h2C);
        dat(8'hF8); dat(8'h00);
        settle();
        check("t1_nbytes", 64'(vb_q.size()), 64'd13);
        for (int i = 0; i < 13; i++) begin
            check($sformatf("t1_byte%0d", i),
                  (i < vb_q.size()) ? {vdc_q[i], vb_q[i]} : 9'h1xx,
                  {exp1_dc[i], exp1_b[i]});
        end
        check("t1_latency", (vcyc_q.size() > 0) ? 64'(vcyc_q[0] - f0) : 64'hFFFF,
              64'(SYNC_STAGES + 2));
        check("t1_npx", 64'(pa_q.size()), 64'd1);
        check("t1_px", (pa_q.size() > 0) ? {pf_q[0], pa_q[0], pd_q[0]} : 33'h1_FFFF_FFFF,
              {1'b0, 16'h0000, 16'hF800});

        // ---------------- Test 2: small window wrap and frame_done -----
        clear_logs();
        cmd(8'h2A); dat(8'h00); dat(8'h0A); dat(8'h00); dat(8'h0B);
        cmd(8'h2B); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h06);
        cmd(8'h2C);
        for (int i = 0; i < 5; i++) pixel(16'h1234);
        settle();
        check("t2_npx", 64'(pa_q.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_px%0d", i),
                  (i < pa_q.size()) ? {pf_q[i], pa_q[i], pd_q[i]} : 33'h1_FFFF_FFFF,
                  {exp2_f[i], exp2_a[i], 16'h1234});
        end

        // ---------------- Test 3: command drops a pending half pixel ---
        clear_logs();
        cmd(8'h2C); dat(8'hAB);
        cmd(8'h29);
        cmd(8'h2C); dat(8'h00); dat(8'hFF);
        settle();
        check("t3_npx", 64'(pa_q.size()), 64'd1);
        check("t3_px", (pa_q.size() > 0) ? {pa_q[0], pd_q[0]} : 32'hFFFF_FFFF,
              {16'h050A, 16'h00FF});

        // ---------------- Test 4: res_i low mid-byte -------------------
        clear_logs();
        send_bits(1'b1, 8'hA5, 5);
        @(posedge clk); #1;
        res_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t4_res_outputs", 64'(all_outs()), 64'd0);
        repeat (90) @(posedge clk);
        #1;
        res_i = 1'b1;
        repeat (5) @(posedge clk);
        check("t4_no_partial", 64'(vb_q.size()), 64'd0);
        clear_logs();
        cmd(8'h2C);
        pixel(16'h0001);
        settle();
        check("t4_nbytes", 64'(vb_q.size()), 64'd3);
        check("t4_byte0", (vb_q.size() > 0) ? {vdc_q[0], vb_q[0]} : 9'h1xx, {1'b0, 8'h2C});
        check("t4_px", (pa_q.size() == 1) ? {pa_q[0], pd_q[0]} : 32'hFFFF_FFFF,
              {16'h0000, 16'h0001});

        // ---------------- Test 5: async rst_i mid-RAMWR ----------------
        clear_logs();
        cmd(8'h2C); dat(8'h55);
        settle();
        check("t5_pre_byte", {byte_dc_o, byte_o}, {1'b1, 8'h55});
        @(posedge clk); #3;
        rst_i = 1'b1;
        #1;
        check("t5_async_outputs", 64'(all_outs()), 64'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        repeat (3) @(posedge clk);
        clear_logs();
        cmd(8'h2C); dat(8'h12); dat(8'h34);
        settle();
        check("t5_npx", 64'(pa_q.size()), 64'd1);
        check("t5_px", (pa_q.size() > 0) ? {pa_q[0], pd_q[0]} : 32'hFFFF_FFFF,
              {16'h0000, 16'h1234});

        // ---------------- Test 6: SWRESET restores 240x240 window ------
        clear_logs();
        cmd(8'h2A); dat(8'h00); dat(8'h10); dat(8'h00); dat(8'h20);
        cmd(8'h2B); dat(8'h00); dat(8'h10); dat(8'h00); dat(8'h20);
        cmd(8'h01);
        cmd(8'h2C);
        for (int i = 0; i < 242; i++) pixel(16'(i));
        settle();
        check("t6_npx", 64'(pa_q.size()), 64'd242);
        nf = 0;
        for (int i = 0; i < 242; i++) begin
            ea = (i < 240) ? 16'(i) : 16'(16'h0100 + (i - 240));
            check($sformatf("t6_addr%0d", i),
                  (i < pa_q.size()) ? pa_q[i] : 16'hxxxx, ea);
            if (i < pf_q.size() && pf_q[i]) nf++;
        end
        check("t6_no_frame", 64'(nf), 64'd0);
        // Only start values are sent, so the ends stay at the reset default.
        clear_logs();
        cmd(8'h2A); dat(8'h00); dat(8'hEE);
        cmd(8'h2B); dat(8'h00); dat(8'hEF);
        cmd(8'h2C);
        for (int i = 0; i < 3; i++) pixel(16'hBEEF);
        settle();
        check("t6_end_npx", 64'(pa_q.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t6_end_px%0d", i),
                  (i < pa_q.size()) ? {pf_q[i], pa_q[i]} : 17'h1_FFFF,
                  {exp6_f[i], exp6_a[i]});
        end
        check("stray_frame_done", 64'(stray_fd), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
